imem_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the combinational word-aligned instruction memory of the ARM-like CPU. It owns the fetch PC, drives the imem address, and captures each returned word into a small prefetch queue. The queue is presented to decode over a valid/ready handshake. Branch redirects from execute flush the queue and restart fetch at the target.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue.sv | 68 ++++++
 rtl/imem_fetch_ctrl.sv | 71 +++++++
 tb/tb_imem_fetch_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state type, constants and helpers for instruction fetch
package fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] WORD_BYTES        = 32'd4;
  localparam logic [31:0] PC_VISIBLE_OFFSET = 32'd8;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch FIFO of {instr, pc} entries with flush over push priority
module fetch_queue #(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [31:0]   push_instr,
  input  logic [31:0]   push_pc,
  output logic [CW-1:0] count,
  output logic          head_valid,
  output logic [31:0]   head_instr,
  output logic [31:0]   head_pc
);

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign head_valid = (count != '0);
  assign head_instr = instr_mem[head];
  assign head_pc    = pc_mem[head];
  assign do_pop     = pop & head_valid;
  // A pop frees the head slot in the same edge, so a full queue may still accept.
  assign do_push    = push & ((count < CW'(DEPTH)) | do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        instr_mem[tail] <= push_instr;
        pc_mem[tail]    <= push_pc;
        tail            <= next_ptr(tail);
      end
      if (do_pop) begin
        head <= next_ptr(head);
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - fetch PC sequencer feeding decode from a prefetch queue
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_en,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc8,
  input  logic        instr_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign imem_a    = fetch_pc;
  assign pop       = instr_valid & instr_ready;
  // Redirect wins over push; the redirect target is fetched on the following edge.
  assign push      = (state == RUN) & fetch_en & ~redirect_valid
                   & ((count < CW'(DEPTH)) | pop);
  assign instr_pc8 = instr_pc + PC_VISIBLE_OFFSET;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      fetch_pc <= word_align(RESET_PC);
    end else begin
      case (state)
        IDLE:    if (fetch_en)  state <= RUN;
        RUN:     if (!fetch_en) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (redirect_valid) begin
        fetch_pc <= word_align(redirect_pc);
      end else if (push) begin
        fetch_pc <= fetch_pc + WORD_BYTES;
      end
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_instr(imem_rd),
    .push_pc   (fetch_pc),
    .count     (count),
    .head_valid(instr_valid),
    .head_instr(instr),
    .head_pc   (instr_pc)
  );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - scoreboard bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc8;
  logic        instr_ready;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] expq[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'hE000_0000 + {2'b00, a[31:2]};
  endfunction

  assign imem_rd = imem_word(imem_a);

  imem_fetch_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fetch_en      (fetch_en),
    .imem_a        (imem_a),
    .imem_rd       (imem_rd),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_pc8     (instr_pc8),
    .instr_ready   (instr_ready)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({instr_valid, instr, instr_pc, instr_pc8, imem_a} !== {1'b0, 32'h0, 32'h0, 32'h8, 32'h0})
      $display("FAIL reset_values: got valid=%b instr=%h pc=%h pc8=%h a=%h want 0 0 0 8 0",
               instr_valid, instr, instr_pc, instr_pc8, imem_a);
    else passed++;
  endtask

  task automatic test_startup();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) expq.push_back(32'(i * 4));
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) $display("FAIL startup_bubble: got valid=%b want 0", instr_valid);
    else passed++;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || expq.size() == 0)
        $display("FAIL startup_stream[%0d]: got valid=%b pending=%0d want valid head", i, instr_valid, expq.size());
      else begin
        e = expq.pop_front();
        if ({instr, instr_pc, instr_pc8} !== {imem_word(e), e, e + 32'd8})
          $display("FAIL startup_stream[%0d]: got %h/%h/%h want %h/%h/%h", i, instr, instr_pc, instr_pc8, imem_word(e), e, e + 32'd8);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, imem_word(32'h10), 32'h10})
        $display("FAIL stall_hold[%0d]: got valid=%b instr=%h pc=%h want 1 %h 10", k, instr_valid, instr, instr_pc, imem_word(32'h10));
      else passed++;
      @(negedge clk);
    end
    checks++;
    if (imem_a !== 32'h18) $display("FAIL stall_imem_a: got %h want 00000018", imem_a);
    else passed++;
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) expq.push_back(32'h10 + 32'(i * 4));
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || expq.size() == 0)
        $display("FAIL stall_release[%0d]: got valid=%b pending=%0d want valid head", i, instr_valid, expq.size());
      else begin
        e = expq.pop_front();
        if ({instr, instr_pc, instr_pc8} !== {imem_word(e), e, e + 32'd8})
          $display("FAIL stall_release[%0d]: got %h/%h/%h want %h/%h/%h", i, instr, instr_pc, instr_pc8, imem_word(e), e, e + 32'd8);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    for (int i = 0; i < 4; i++) expq.push_back(32'h40 + 32'(i * 4));
    @(negedge clk);
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    checks++;
    if ({instr_valid, imem_a} !== {1'b0, 32'h40})
      $display("FAIL redirect_flush: got valid=%b a=%h want 0 00000040", instr_valid, imem_a);
    else passed++;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || expq.size() == 0)
        $display("FAIL redirect_stream[%0d]: got valid=%b pending=%0d want valid head", i, instr_valid, expq.size());
      else begin
        e = expq.pop_front();
        if ({instr, instr_pc, instr_pc8} !== {imem_word(e), e, e + 32'd8})
          $display("FAIL redirect_stream[%0d]: got %h/%h/%h want %h/%h/%h", i, instr, instr_pc, instr_pc8, imem_word(e), e, e + 32'd8);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    expq.push_back(32'hFFFF_FFFC);
    expq.push_back(32'h0);
    expq.push_back(32'h4);
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) $display("FAIL wrap_bubble: got valid=%b want 0", instr_valid);
    else passed++;
    @(negedge clk);
    checks++;
    if (instr_pc8 !== 32'h4) $display("FAIL wrap_pc8: got %h want 00000004", instr_pc8);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || expq.size() == 0)
        $display("FAIL wrap_stream[%0d]: got valid=%b pending=%0d want valid head", i, instr_valid, expq.size());
      else begin
        e = expq.pop_front();
        if ({instr, instr_pc, instr_pc8} !== {imem_word(e), e, e + 32'd8})
          $display("FAIL wrap_stream[%0d]: got %h/%h/%h want %h/%h/%h", i, instr, instr_pc, instr_pc8, imem_word(e), e, e + 32'd8);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fetch_en_drop();
    instr_ready = 1'b0;
    @(negedge clk);
    fetch_en    = 1'b0;
    instr_ready = 1'b1;
    expq.push_back(32'h8);
    expq.push_back(32'hC);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || expq.size() == 0)
        $display("FAIL en_drain[%0d]: got valid=%b pending=%0d want valid head", i, instr_valid, expq.size());
      else begin
        e = expq.pop_front();
        if ({instr, instr_pc, instr_pc8} !== {imem_word(e), e, e + 32'd8})
          $display("FAIL en_drain[%0d]: got %h/%h/%h want %h/%h/%h", i, instr, instr_pc, instr_pc8, imem_word(e), e, e + 32'd8);
        else passed++;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({instr_valid, imem_a} !== {1'b0, 32'h10})
        $display("FAIL en_idle[%0d]: got valid=%b a=%h want 0 00000010", k, instr_valid, imem_a);
      else passed++;
      @(negedge clk);
    end
    fetch_en = 1'b1;
    for (int i = 0; i < 3; i++) expq.push_back(32'h10 + 32'(i * 4));
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) $display("FAIL en_restart_bubble: got valid=%b want 0", instr_valid);
    else passed++;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || expq.size() == 0)
        $display("FAIL en_resume[%0d]: got valid=%b pending=%0d want valid head", i, instr_valid, expq.size());
      else begin
        e = expq.pop_front();
        if ({instr, instr_pc, instr_pc8} !== {imem_word(e), e, e + 32'd8})
          $display("FAIL en_resume[%0d]: got %h/%h/%h want %h/%h/%h", i, instr, instr_pc, instr_pc8, imem_word(e), e, e + 32'd8);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    instr_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({instr_valid, instr_pc, imem_a} !== {1'b1, 32'h1C, 32'h24})
      $display("FAIL areset_pre: got valid=%b pc=%h a=%h want 1 0000001c 00000024", instr_valid, instr_pc, imem_a);
    else passed++;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({instr_valid, instr, instr_pc, instr_pc8, imem_a} !== {1'b0, 32'h0, 32'h0, 32'h8, 32'h0})
      $display("FAIL areset_values: got valid=%b instr=%h pc=%h pc8=%h a=%h want 0 0 0 8 0",
               instr_valid, instr, instr_pc, instr_pc8, imem_a);
    else passed++;
    @(negedge clk);
    reset_n     = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) expq.push_back(32'(i * 4));
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) $display("FAIL areset_bubble: got valid=%b want 0", instr_valid);
    else passed++;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || expq.size() == 0)
        $display("FAIL areset_refetch[%0d]: got valid=%b pending=%0d want valid head", i, instr_valid, expq.size());
      else begin
        e = expq.pop_front();
        if ({instr, instr_pc, instr_pc8} !== {imem_word(e), e, e + 32'd8})
          $display("FAIL areset_refetch[%0d]: got %h/%h/%h want %h/%h/%h", i, instr, instr_pc, instr_pc8, imem_word(e), e, e + 32'd8);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    fetch_en       = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_wrap();
    test_fetch_en_drop();
    test_async_reset();
    checks++;
    if (expq.size() != 0) $display("FAIL scoreboard_drained: got %0d pending want 0", expq.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
